// File: rtl/rvvi_trace_serializer.sv
// Serializes one retired instruction per handshake into key/index/value trace records.
// A single snapshot register holds the instruction; the next record is registered onto out_*.
module rvvi_trace_serializer #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned FLEN = 64,
  parameter int unsigned DW   = (XLEN > FLEN) ? XLEN : FLEN
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               retire_valid,
  output logic               retire_ready,
  input  logic [31:0]        insn,
  input  logic [XLEN-1:0]    pc_rdata,
  input  logic [1:0]         mode,
  input  logic               trap,
  input  logic [31:0]        x_wb,
  input  logic [32*XLEN-1:0] x_wdata,
  input  logic [31:0]        f_wb,
  input  logic [32*FLEN-1:0] f_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_key,
  output logic [4:0]         out_idx,
  output logic [DW-1:0]      out_data,
  output logic               out_last,
  output logic [31:0]        out_order
);

  typedef enum logic [1:0] {StIdle, StHdr, StXreg, StFreg} state_e;

  state_e              state_q, state_d;
  logic [1:0]          hcnt_q, hcnt_d;
  logic [31:0]         insn_q, insn_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [1:0]          mode_q, mode_d;
  logic                trap_q, trap_d;
  logic [31:0]         xmask_q, xmask_d;
  logic [32*XLEN-1:0]  xdata_q, xdata_d;
  logic [31:0]         fmask_q, fmask_d;
  logic [32*FLEN-1:0]  fdata_q, fdata_d;
  logic [31:0]         order_q, order_d;
  logic                valid_q, valid_d;
  logic [2:0]          key_q, key_d;
  logic [4:0]          idx_q, idx_d;
  logic [DW-1:0]       data_q, data_d;
  logic                last_q, last_d;

  logic                capture, advance;
  logic [4:0]          xsel_q, fsel_q, xsel_d, fsel_d;

  function automatic logic [4:0] lowest_bit(input logic [31:0] m);
    logic [4:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) r = 5'(i);
    end
    return r;
  endfunction

  assign advance      = valid_q && out_ready;
  assign retire_ready = reset_n && ((state_q == StIdle) || (advance && last_q));
  assign capture      = retire_valid && retire_ready;

  assign xsel_q = lowest_bit(xmask_q);
  assign fsel_q = lowest_bit(fmask_q);
  assign xsel_d = lowest_bit(xmask_d);
  assign fsel_d = lowest_bit(fmask_d);

  // Walk position: snapshot and FSM advance on capture or on an accepted record.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    insn_d  = insn_q;
    pc_d    = pc_q;
    mode_d  = mode_q;
    trap_d  = trap_q;
    xmask_d = xmask_q;
    xdata_d = xdata_q;
    fmask_d = fmask_q;
    fdata_d = fdata_q;
    order_d = order_q;
    if (capture) begin
      state_d = StHdr;
      hcnt_d  = '0;
      insn_d  = insn;
      pc_d    = pc_rdata;
      mode_d  = mode;
      trap_d  = trap;
      xmask_d = {x_wb[31:1], 1'b0};
      xdata_d = x_wdata;
      fmask_d = f_wb;
      fdata_d = f_wdata;
      order_d = order_q + 32'd1;
    end else if (advance) begin
      unique case (state_q)
        StHdr: begin
          if (hcnt_q == 2'd3) begin
            if (xmask_q != '0)      state_d = StXreg;
            else if (fmask_q != '0) state_d = StFreg;
            else                    state_d = StIdle;
          end else begin
            hcnt_d = hcnt_q + 2'd1;
          end
        end
        StXreg: begin
          xmask_d = xmask_q & ~(32'd1 << xsel_q);
          if (xmask_d == '0) state_d = (fmask_q != '0) ? StFreg : StIdle;
        end
        StFreg: begin
          fmask_d = fmask_q & ~(32'd1 << fsel_q);
          if (fmask_d == '0) state_d = StIdle;
        end
        default: ;
      endcase
    end
  end

  // Record presented at the new position; recomputes to the same value while stalled.
  always_comb begin
    valid_d = (state_d != StIdle);
    key_d   = '0;
    idx_d   = '0;
    data_d  = '0;
    last_d  = 1'b0;
    unique case (state_d)
      StHdr: begin
        key_d  = {1'b0, hcnt_d} + 3'd1;
        last_d = (hcnt_d == 2'd3) && (xmask_d == '0) && (fmask_d == '0);
        unique case (hcnt_d)
          2'd0:    data_d = DW'(insn_d);
          2'd1:    data_d = DW'(pc_d);
          2'd2:    data_d = DW'(mode_d);
          default: data_d = DW'(trap_d);
        endcase
      end
      StXreg: begin
        key_d  = 3'd5;
        idx_d  = xsel_d;
        data_d = DW'(xdata_d[xsel_d*XLEN +: XLEN]);
        last_d = ((xmask_d & (xmask_d - 32'd1)) == '0) && (fmask_d == '0);
      end
      StFreg: begin
        key_d  = 3'd6;
        idx_d  = fsel_d;
        data_d = DW'(fdata_d[fsel_d*FLEN +: FLEN]);
        last_d = ((fmask_d & (fmask_d - 32'd1)) == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      insn_q  <= '0;
      pc_q    <= '0;
      mode_q  <= '0;
      trap_q  <= 1'b0;
      xmask_q <= '0;
      xdata_q <= '0;
      fmask_q <= '0;
      fdata_q <= '0;
      order_q <= '0;
      valid_q <= 1'b0;
      key_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      insn_q  <= insn_d;
      pc_q    <= pc_d;
      mode_q  <= mode_d;
      trap_q  <= trap_d;
      xmask_q <= xmask_d;
      xdata_q <= xdata_d;
      fmask_q <= fmask_d;
      fdata_q <= fdata_d;
      order_q <= order_d;
      valid_q <= valid_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_key   = key_q;
  assign out_idx   = idx_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_order = order_q;

endmodule

// File: doc/rvvi_trace_serializer.md
Name: rvvi_trace_serializer

Overview:
- Takes one retired instruction per handshake on an RVVI-style retire port.
- Serializes it into a stream of key/index/value records: the same field set (INSN, PC, MODE, TRAP, X, F) that the coverage testbench parses from trace files.
- Sits between a DUT's RVVI tap and a trace sink (DPI file writer or FIFO to host), so that lockstep traces can be produced from RTL simulation.

Parameters:
- XLEN, 64, integer register width (32 or 64).
- FLEN, 64, FP register width (32 or 64).
- DW, (XLEN>FLEN?XLEN:FLEN), record data width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- retire_valid  in  1  retire record offered.
- retire_ready  out  1  serializer can capture a record.
- insn  in  32  instruction word.
- pc_rdata  in  XLEN  instruction PC.
- mode  in  2  privilege mode.
- trap  in  1  instruction trapped.
- x_wb  in  32  integer writeback mask.
- x_wdata  in  32*XLEN  integer write data; reg i at [i*XLEN +: XLEN].
- f_wb  in  32  FP writeback mask.
- f_wdata  in  32*FLEN  FP write data; reg i at [i*FLEN +: FLEN].
- out_valid  out  1  record valid.
- out_ready  in  1  sink accepts record.
- out_key  out  3  1=INSN 2=PC 3=MODE 4=TRAP 5=X 6=F; 0 unused.
- out_idx  out  5  register index for X/F, else 0.
- out_data  out  DW  value, zero-extended.
- out_last  out  1  final record of the instruction.
- out_order  out  32  instruction sequence number, first instruction = 1.

Behaviour:
- Reset (async assert, sync deassert):
  - out_valid=0, out_key=0, out_idx=0, out_data=0, out_last=0, out_order=0.
  - FSM goes to IDLE and the snapshot is cleared.
  - retire_ready=0 while reset_n=0.
- Reset mid-instruction drops the remainder of the instruction. No partial record is emitted after reset.
- Capture occurs on retire_valid&&retire_ready. It snapshots insn, pc_rdata, mode, trap, x_wb with bit0 forced to 0, x_wdata, f_wb and f_wdata, and increments the order counter.
- retire_ready = IDLE || (out_valid && out_ready && out_last). This gives back-to-back throughput with a single snapshot register.
- Latency: capture at edge N; the first record (INSN) is presented with out_valid=1 after edge N.
- FSM states:
  - IDLE: out_valid=0. Capture moves to HDR.
  - HDR: a 2-bit counter emits INSN, PC, MODE, TRAP in that order. TRAP is always emitted, value 0 or 1. After TRAP is accepted: go to XREG if the pending X mask is nonzero, else FREG if the pending F mask is nonzero, else IDLE (or HDR if a new capture occurs in the same cycle).
  - XREG: a priority encoder selects the lowest set bit of the pending X mask. The record is key=5, idx=bit, data=x_wdata[bit]. That bit is cleared on acceptance. When the mask empties, go to FREG or end.
  - FREG: same as XREG using the F mask, key=6, data zero-extended from FLEN.
- out_last marks the final record (last set F bit, else last set X bit, else TRAP).
- Record count = 4 + popcount(x_wb[31:1]) + popcount(f_wb).
- Output handshake: outputs are registered.
  - While out_valid && !out_ready, every out_* value is held stable.
  - A record advances only on out_valid&&out_ready.
  - out_valid never drops without a handshake, except on reset.
- out_order is constant across all records of one instruction. It wraps from 0xFFFFFFFF to 0.
- Inputs are sampled only at capture. Changes to inputs after capture have no effect.
- x_wb[0] is never emitted. f_wb[0] is emitted normally.

Test Plan:
1. Single retire: insn=0x00500093, pc=0x80000000, mode=3, trap=0, x_wb=0x2, x1=5 -> exactly 5 records, first INSN valid 1 cycle after capture:
   - (1,0,0x00500093)
   - (2,0,0x80000000)
   - (3,0,3)
   - (4,0,0)
   - (5,1,5) with out_last=1
   - out_order=1 on all five.
2. x_wb=0x1, f_wb=0, trap=1 -> 4 records, TRAP data=1 with out_last=1; no X record for x0.
3. x_wb=0x80000002, f_wb=0x1, f0=0x3FF0000000000000 -> X1, X31, F0 in that order; last asserted only on F0.
4. Backpressure: out_ready=0 for 3 cycles while the PC record is presented -> key/data/last held stable; PC emitted once; MODE follows the next accepting cycle.
5. Back-to-back: retire_valid held for two instructions with out_ready=1 -> second captured on the cycle the first's last record is accepted; no bubble; out_order 1 then 2.
6. reset_n pulsed low during XREG -> out_valid=0 immediately (asynchronously); after release retire_ready=1, no stale records; next instruction has out_order=1.
